// File: rtl/wb_prefetch_pkg.sv
// wb_prefetch_pkg
// Shared definitions for the Wishbone instruction prefetcher:
//   state_t          - bus FSM encoding (IDLE / BUS)
//   WB_SEL_WORD      - byte-lane select driven on every fetch
//   WB_TGA_MEM       - address tag selecting memory space
//   RESET_PC_DEFAULT - default first fetch address after reset
package wb_prefetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [1:0]  WB_SEL_WORD      = 2'b11;
    localparam logic        WB_TGA_MEM       = 1'b0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
// DEPTH x WIDTH synchronous FIFO holding {instruction, address} pairs.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, push_data - write request and data (dropped when full without pop)
//   pop           - remove head (ignored when empty)
//   flush         - empty the FIFO; a push in the same cycle is discarded
//   head          - registered copy of the head entry after this cycle's ops
//   count, empty, full - occupancy status
// Valid/ready: an entry is consumed only on a cycle where pop is high and
// empty is low; a push is accepted when not full (or when a pop frees a slot).
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;

    logic             pop_eff;
    logic             push_eff;
    logic [CW-1:0]    count_after_pop;

    assign empty           = (count_q == '0);
    assign full            = (count_q == CW'(DEPTH));
    assign pop_eff         = pop & ~empty;
    assign push_eff        = push & ~flush & (~full | pop_eff);
    assign count_after_pop = count_q - CW'(pop_eff);

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_after_pop + CW'(push_eff);
            // The head register tracks what the head will be after this edge:
            // a push into an (effectively) empty FIFO bypasses straight to it,
            // otherwise a pop exposes the next stored entry.
            if (push_eff && (count_after_pop == '0)) begin
                head_q <= push_data;
            end else if (pop_eff && (count_after_pop != '0)) begin
                head_q <= mem[rd_ptr + AW'(1)];
            end
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/wb_prefetch.sv
// wb_prefetch
// Wishbone classic read master that fetches sequential 32-bit instruction
// words from fetch_pc and buffers {word, address} in a small FIFO for the
// fetch stage. A branch flushes the FIFO, abandons any bus cycle and restarts
// fetching at the (word-aligned) target.
// Optional feature macro: WB_PREFETCH_TIMEOUT_EN - ack watchdog; after TIMEOUT
// unacknowledged BUS cycles the request is dropped, err_o pulses and the same
// address is retried.
// Ports:
//   clk_i, rst_i               - clock, synchronous active-high reset
//   branch_i, branch_target_i  - flush and redirect
//   pop_i, valid_o             - consumer handshake on the FIFO head
//   insn_o, insn_adr_o         - head word and its byte address
//   wb_*                       - Wishbone classic master (read only)
//   err_o                      - bus timeout pulse (0 without the feature)
//   dbg_state                  - current bus FSM state
// Handshake: the head is consumed on a cycle where valid_o and pop_i are both
// high; pop_i while valid_o is low, or together with branch_i, has no effect.
module wb_prefetch
    import wb_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        pop_i,
    output logic        valid_o,
    output logic [31:0] insn_o,
    output logic [31:0] insn_adr_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        err_o,
    output state_t      dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("wb_prefetch: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    state_t        state;
    logic [31:0]   fetch_pc;
    logic          cyc_q;

    logic          push;
    logic          pop_eff;
    logic [63:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] count_after;
    logic          tmo_hit;
    logic          unused_tgt_lsb;

    // Bits [1:0] of the target are forced to zero.
    assign unused_tgt_lsb = ^branch_target_i[1:0];

    assign push        = (state == BUS) & wb_ack_i & ~branch_i;
    assign pop_eff     = pop_i & ~fifo_empty;
    assign count_after = fifo_count + CW'(push) - CW'(pop_eff);

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data ({wb_dat_i, fetch_pc}),
        .pop       (pop_i),
        .flush     (branch_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef WB_PREFETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == BUS) & ~wb_ack_i & (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || branch_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state != BUS || wb_ack_i || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Bus FSM. cyc/stb are one register; wb_adr_o is fetch_pc itself, so all
    // Wishbone outputs come straight from flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            cyc_q    <= 1'b0;
        end else if (branch_i) begin
            state    <= IDLE;
            fetch_pc <= {branch_target_i[31:2], 2'b00};
            cyc_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        state <= BUS;
                        cyc_q <= 1'b1;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        // Only keep requesting while a slot is guaranteed free.
                        if (count_after >= CW'(DEPTH)) begin
                            state <= IDLE;
                            cyc_q <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb_adr_o   = fetch_pc;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = WB_SEL_WORD;
    assign wb_tga_o   = WB_TGA_MEM;
    assign valid_o    = ~fifo_empty;
    assign insn_o     = fifo_head[63:32];
    assign insn_adr_o = fifo_head[31:0];
    assign dbg_state  = state;

endmodule

// File: tb/tb_wb_prefetch.sv
// tb_wb_prefetch
// Directed bench for wb_prefetch against a combinational-ack RAM model.
// Memory model: word at 0x1000 is 0x11223344, every other word is
// address ^ 0xDEAD0000.
module tb_wb_prefetch;
    import wb_prefetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        branch;
    logic [31:0] target;
    logic        pop;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] insn_adr;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic        wb_tga;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic        err;
    state_t      dbg_state;
    logic        ack_en;

    wb_prefetch dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .branch_i        (branch),
        .branch_target_i (target),
        .pop_i           (pop),
        .valid_o         (valid),
        .insn_o          (insn),
        .insn_adr_o      (insn_adr),
        .wb_adr_o        (wb_adr),
        .wb_dat_i        (wb_dat),
        .wb_we_o         (wb_we),
        .wb_sel_o        (wb_sel),
        .wb_tga_o        (wb_tga),
        .wb_stb_o        (wb_stb),
        .wb_cyc_o        (wb_cyc),
        .wb_ack_i        (wb_ack),
        .err_o           (err),
        .dbg_state       (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h1122_3344;
        return a ^ 32'hDEAD_0000;
    endfunction

    assign wb_ack = wb_cyc & wb_stb & ack_en;
    assign wb_dat = mem_word(wb_adr);

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        branch;
        logic [31:0] target;
        logic        pop;
        logic        ack_en;
        logic        exp_cyc;
        logic [31:0] exp_adr;
        logic        exp_valid;
        logic [31:0] exp_insn;
        logic [31:0] exp_iadr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic [31:0] t, input logic p,
                       input logic a, input logic ec, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] eia);
        vec_t v;
        v.rst = r; v.branch = b; v.target = t; v.pop = p; v.ack_en = a;
        v.exp_cyc = ec; v.exp_adr = ea; v.exp_valid = ev; v.exp_insn = ei; v.exp_iadr = eia;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] model_adr;
        logic [63:0] e;
        vec_t v;

        rst = 1'b1; branch = 1'b0; target = '0; pop = 1'b0; ack_en = 1'b0;

        // Reset, fill to full with no pops, then drain / refill with a wait state.
        add(1,0,32'h0,0,0, 0,32'h00001000,0,32'h0,32'h0);
        add(1,0,32'h0,0,0, 0,32'h00001000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00001000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00001004,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 1,32'h00001008,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 1,32'h0000100C,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 0,32'h00001010,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 0,32'h00001010,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,1,1, 0,32'h00001010,1,32'hDEAD1004,32'h00001004);
        add(0,0,32'h0,1,1, 1,32'h00001010,1,32'hDEAD1008,32'h00001008);
        add(0,0,32'h0,0,1, 1,32'h00001014,1,32'hDEAD1008,32'h00001008);
        add(0,0,32'h0,0,0, 1,32'h00001014,1,32'hDEAD1008,32'h00001008);
        add(0,0,32'h0,0,1, 0,32'h00001018,1,32'hDEAD1008,32'h00001008);
        add(0,0,32'h0,1,0, 0,32'h00001018,1,32'hDEAD100C,32'h0000100C);
        // Reset, then branch to 0x2003 on the same edge as the ack at 0x100C.
        add(1,0,32'h0,0,0, 0,32'h00001000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00001000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00001004,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 1,32'h00001008,1,32'h11223344,32'h00001000);
        add(0,0,32'h0,0,1, 1,32'h0000100C,1,32'h11223344,32'h00001000);
        add(0,1,32'h00002003,1,1, 0,32'h00002000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00002000,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'h00002004,1,32'hDEAD2000,32'h00002000);
        // Address wrap via branch to 0xFFFFFFF8, then back-to-back branches.
        add(0,1,32'hFFFFFFF8,0,1, 0,32'hFFFFFFF8,0,32'h0,32'h0);
        add(0,0,32'h0,0,0, 1,32'hFFFFFFF8,0,32'h0,32'h0);
        add(0,0,32'h0,0,1, 1,32'hFFFFFFFC,1,32'h2152FFF8,32'hFFFFFFF8);
        add(0,0,32'h0,1,1, 1,32'h00000000,1,32'h2152FFFC,32'hFFFFFFFC);
        add(0,0,32'h0,1,1, 1,32'h00000004,1,32'hDEAD0000,32'h00000000);
        add(0,1,32'h00003000,0,1, 0,32'h00003000,0,32'h0,32'h0);
        add(0,1,32'h00004001,0,1, 0,32'h00004000,0,32'h0,32'h0);
        add(0,0,32'h0,0,0, 1,32'h00004000,0,32'h0,32'h0);
        // Reset while a request is outstanding and ack is withheld.
        add(1,0,32'h0,0,0, 0,32'h00001000,0,32'h0,32'h0);
        add(0,0,32'h0,0,0, 1,32'h00001000,0,32'h0,32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst; branch = v.branch; target = v.target; pop = v.pop; ack_en = v.ack_en;
            step();
            chk($sformatf("v%0d cyc", i), {31'b0, wb_cyc}, {31'b0, v.exp_cyc});
            chk($sformatf("v%0d stb", i), {31'b0, wb_stb}, {31'b0, v.exp_cyc});
            chk($sformatf("v%0d state", i), {31'b0, dbg_state == BUS}, {31'b0, v.exp_cyc});
            chk($sformatf("v%0d adr", i), wb_adr, v.exp_adr);
            chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, v.exp_valid});
            chk($sformatf("v%0d err", i), {31'b0, err}, 32'h0);
            if (v.exp_valid || v.rst) begin
                chk($sformatf("v%0d insn", i), insn, v.exp_insn);
                chk($sformatf("v%0d insn_adr", i), insn_adr, v.exp_iadr);
            end
            if (v.rst) begin
                chk($sformatf("v%0d we", i), {31'b0, wb_we}, 32'h0);
                chk($sformatf("v%0d sel", i), {30'b0, wb_sel}, 32'h3);
                chk($sformatf("v%0d tga", i), {31'b0, wb_tga}, 32'h0);
            end
        end

        // Streaming: pop whenever valid; the bus must never pause.
        model_adr = 32'h0000_1000;
        ack_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("stream%0d cyc", c), {31'b0, wb_cyc}, 32'h1);
            chk($sformatf("stream%0d adr", c), wb_adr, model_adr);
            if (c > 0) chk($sformatf("stream%0d valid", c), {31'b0, valid}, 32'h1);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stream%0d queue: got word, expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d insn", c), insn, e[63:32]);
                    chk($sformatf("stream%0d insn_adr", c), insn_adr, e[31:0]);
                end
                pop = 1'b1;
            end else begin
                pop = 1'b0;
            end
            exp_q.push_back({mem_word(model_adr), model_adr});
            model_adr = model_adr + 32'd4;
            step();
        end
        pop = 1'b0;

        // Ack withheld from the first request after reset.
        rst = 1'b1; ack_en = 1'b0;
        step();
        rst = 1'b0;
        step();
`ifdef WB_PREFETCH_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("tmo%0d cyc", k), {31'b0, wb_cyc}, 32'h1);
            chk($sformatf("tmo%0d err", k), {31'b0, err}, 32'h0);
            if (k < 15) step();
        end
        step();
        chk("tmo drop cyc", {31'b0, wb_cyc}, 32'h0);
        chk("tmo err pulse", {31'b0, err}, 32'h1);
        chk("tmo keep adr", wb_adr, 32'h0000_1000);
        step();
        chk("retry cyc", {31'b0, wb_cyc}, 32'h1);
        chk("retry err", {31'b0, err}, 32'h0);
        chk("retry adr", wb_adr, 32'h0000_1000);
        ack_en = 1'b1;
        step();
        chk("retry valid", {31'b0, valid}, 32'h1);
        chk("retry insn", insn, 32'h1122_3344);
        chk("retry insn_adr", insn_adr, 32'h0000_1000);
        chk("retry next adr", wb_adr, 32'h0000_1004);
`else
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("wait%0d cyc", k), {31'b0, wb_cyc}, 32'h1);
            chk($sformatf("wait%0d err", k), {31'b0, err}, 32'h0);
            step();
        end
        ack_en = 1'b1;
        step();
        chk("late ack valid", {31'b0, valid}, 32'h1);
        chk("late ack insn", insn, 32'h1122_3344);
        chk("late ack adr", wb_adr, 32'h0000_1004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
